// File: rtl/morse_tx_arbiter.sv
// Round-robin arbiter that hands complete ASCII messages from N_REQ requesters to one Morse keyer.
// Define MORSE_ARB_GAP_EN to add a timed inter-message silence (GAP state) after each message.
module morse_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int UNIT_DIV  = 1000,
  parameter int GAP_UNITS = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_char,
  output logic               o_char_valid,
  input  logic               i_char_ready,
  input  logic               i_keyer_busy,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_CYC = GAP_UNITS * UNIT_DIV;

`ifdef MORSE_ARB_GAP_EN
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  logic unused_gap_cfg;
  assign unused_gap_cfg = (GAP_CYC != 0);
`endif

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_r, grant_nxt;
  logic [IDX_W-1:0] gidx, gidx_nxt;
  logic [IDX_W-1:0] last_win, last_win_nxt;
  logic [IDX_W-1:0] win_idx, cand;
  logic             win_found;
  logic             vld_g, last_g, xfer_go;
  logic [7:0]       char_g;

  // Round-robin search starting just after the previous message owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_win) + i) % N_REQ);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    vld_g  = 1'b0;
    last_g = 1'b0;
    char_g = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (gidx == IDX_W'(k)) begin
        vld_g  = i_req_valid[k];
        last_g = i_req_last[k];
        char_g = i_req_data[8*k +: 8];
      end
    end
  end

  assign xfer_go = (state == XFER) && vld_g && i_char_ready;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_r;
    gidx_nxt     = gidx;
    last_win_nxt = last_win;
`ifdef MORSE_ARB_GAP_EN
    gap_cnt_nxt  = gap_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = XFER;
          gidx_nxt  = win_idx;
          grant_nxt = N_REQ'(1) << win_idx;
        end
      end
      XFER: begin
        if (xfer_go && last_g) begin
          state_nxt    = DRAIN;
          last_win_nxt = gidx;
        end
      end
      DRAIN: begin
        if (!i_keyer_busy) begin
`ifdef MORSE_ARB_GAP_EN
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
`else
          state_nxt   = IDLE;
          grant_nxt   = '0;
`endif
        end
      end
`ifdef MORSE_ARB_GAP_EN
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= IDLE;
      grant_r  <= '0;
      gidx     <= '0;
      last_win <= IDX_W'(N_REQ - 1);
`ifdef MORSE_ARB_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      grant_r  <= grant_nxt;
      gidx     <= gidx_nxt;
      last_win <= last_win_nxt;
`ifdef MORSE_ARB_GAP_EN
      gap_cnt  <= gap_cnt_nxt;
`endif
    end
  end

  // Handshake is a straight pass-through of the owner's lane, forced quiet while reset is held.
  assign o_char_valid = i_rst && (state == XFER) && vld_g;
  assign o_char       = (i_rst && (state == XFER)) ? char_g : 8'h00;
  assign o_req_ready  = (i_rst && (state == XFER) && i_char_ready) ? grant_r : '0;
  assign o_grant      = grant_r;
  assign o_busy       = (state != IDLE);

endmodule

// File: doc/morse_tx_arbiter.md
MORSE_TX_ARBITER -- requirements
Module: morse_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of message requesters (1..8).
REQ-002 SHALL have parameter UNIT_DIV, default 1000, clock cycles per Morse time unit (>=1).
REQ-003 SHALL have parameter GAP_UNITS, default 7, Morse units of inter-message silence.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_req_valid  input  N_REQ  per-requester ASCII character valid.
REQ-007 SHALL have port i_req_data  input  8*N_REQ  per-requester ASCII character; requester k uses bits [8k+7:8k].
REQ-008 SHALL have port i_req_last  input  N_REQ  marks the final character of a message.
REQ-009 SHALL have port o_req_ready  output  N_REQ  per-requester character accept.
REQ-010 SHALL have port o_char  output  8  ASCII character to the Morse keyer.
REQ-011 SHALL have port o_char_valid  output  1  o_char is valid.
REQ-012 SHALL have port i_char_ready  input  1  keyer can accept a character this cycle.
REQ-013 SHALL have port i_keyer_busy  input  1  keyer is still shifting Morse bits out.
REQ-014 SHALL have port o_grant  output  N_REQ  one-hot current owner; zero when none.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, XFER, DRAIN, GAP.
REQ-017 IDLE: when any i_req_valid bit is high, SHALL pick a winner round-robin, searching from (last_winner+1) mod N_REQ upward, load o_grant, and enter XFER next cycle.
REQ-018 Arbitration SHALL consider only i_req_valid; requests arriving during XFER/DRAIN/GAP wait.
REQ-019 XFER: o_char and o_char_valid SHALL combinationally mirror the granted requester's data and valid; o_req_ready[g] = i_char_ready; all other o_req_ready bits 0.
REQ-020 A transfer SHALL occur only on a cycle with i_req_valid[g] & i_char_ready; the arbiter adds no latency and no buffering.
REQ-021 Grant SHALL stay locked across gaps in i_req_valid[g]; no preemption mid-message.
REQ-022 A transfer with i_req_last[g]=1 SHALL move XFER -> DRAIN and record g as last_winner.
REQ-023 DRAIN: o_char_valid and all o_req_ready SHALL be 0; SHALL leave DRAIN on the first cycle i_keyer_busy=0.
REQ-024 GAP: a cycle counter of width ceil(log2(GAP_UNITS*UNIT_DIV+1)) SHALL count GAP_UNITS*UNIT_DIV cycles, then enter IDLE with o_grant=0.
REQ-025 o_grant SHALL stay asserted through DRAIN and GAP and clear on entry to IDLE.
REQ-026 With N_REQ=1 the same FSM SHALL apply; round-robin degenerates to a fixed grant.
REQ-027 Simultaneous requests SHALL be resolved only by the round-robin pointer, never by index.

Reset
REQ-028 On i_rst=0 at a clock edge: state IDLE, o_grant=0, o_busy=0, gap counter 0, last_winner=N_REQ-1 (requester 0 wins first).
REQ-029 While in reset, o_char_valid=0, o_req_ready=0, o_char=8'h00.
REQ-030 Reset mid-message SHALL abandon the message; the next grant after reset follows REQ-028.

Configuration
REQ-031 Macro MORSE_ARB_GAP_EN SHALL compile in the GAP state and counter.
REQ-032 Without MORSE_ARB_GAP_EN, DRAIN SHALL go directly to IDLE and UNIT_DIV/GAP_UNITS SHALL be unused.

Verification (UNIT_DIV=4, GAP_UNITS=7, N_REQ=4, MORSE_ARB_GAP_EN defined unless stated)
REQ-033 Reset, then req0 sends "SK" (8'h53, 8'h4B last), i_char_ready=1 -> o_grant=4'b0001, two transfers, DRAIN, then 28 GAP cycles, then IDLE.
REQ-034 req1 and req3 valid in the same cycle after req0 finished -> req1 granted first, req3 next, then req0 only if re-requesting.
REQ-035 Granted req2 drops valid for 5 cycles mid-message while req0 is valid -> o_grant stays 4'b0100; no req0 transfer until req2's last.
REQ-036 i_char_ready=0 for 10 cycles in XFER -> no transfer and o_req_ready=0 for those cycles; data held unchanged.
REQ-037 i_keyer_busy held 1 for 50 cycles after last -> DRAIN lasts 50 cycles; GAP starts on the cycle after busy drops.
REQ-038 Reset asserted 3 cycles into GAP, and a build without MORSE_ARB_GAP_EN -> the first returns IDLE with o_grant=0 next cycle; the second goes DRAIN->IDLE with no 28-cycle gap.
